// File: rtl/lane_rotator.sv
// N-lane register bank with parallel load, pairwise swap and counted multi-step rotate.
// Single-cycle ops complete at the accept edge; rotates step once per edge while busy.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | cmd_ready high; NOP/LOAD/SWAP applied at the accept edge
// BUSY  | rotating one lane per edge; count holds the remaining steps
module lane_rotator #(
    parameter int N = 3,
    parameter int W = 1,
    parameter int AW = 4,
    parameter logic [N*W-1:0] RESET_VAL = 3'b101
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic            cmd_swap,
    input  logic [AW-1:0]   cmd_amt,
    input  logic [AW-1:0]   swap_a,
    input  logic [AW-1:0]   swap_b,
    input  logic [N*W-1:0]  load_data,
    output logic [N*W-1:0]  q,
    output logic            done,
    output logic            err
);

    typedef enum logic {IDLE, BUSY} state_t;

    // one extra bit so N == 2**AW does not truncate to zero
    localparam logic [AW:0] N_EXT = (AW+1)'(N);

    state_t         state, state_nxt;
    logic [N*W-1:0] q_nxt;
    logic [AW:0]    count, count_nxt;
    logic           dir, dir_nxt;
    logic           done_nxt, err_nxt;
    logic [AW:0]    amt_mod;
    logic           swap_ok;
    logic [W-1:0]   lane_a, lane_b;
    logic [N*W-1:0] rotl_img, rotr_img, swap_img;

    assign amt_mod   = {1'b0, cmd_amt} % N_EXT;
    assign swap_ok   = ({1'b0, swap_a} < N_EXT) && ({1'b0, swap_b} < N_EXT);
    assign cmd_ready = (state == IDLE);

    always_comb begin
        rotl_img = '0;
        rotr_img = '0;
        for (int i = 0; i < N; i++) begin
            rotl_img[i*W +: W] = q[((i + 1) % N)*W +: W];
            rotr_img[i*W +: W] = q[((i + N - 1) % N)*W +: W];
        end
    end

    // both lanes are read from the old image, so the exchange is atomic
    always_comb begin
        lane_a   = '0;
        lane_b   = '0;
        swap_img = q;
        for (int j = 0; j < N; j++) begin
            if (swap_a == AW'(j)) lane_a = q[j*W +: W];
            if (swap_b == AW'(j)) lane_b = q[j*W +: W];
        end
        for (int i = 0; i < N; i++) begin
            if (swap_b == AW'(i)) swap_img[i*W +: W] = lane_a;
            if (swap_a == AW'(i)) swap_img[i*W +: W] = lane_b;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        count_nxt = count;
        dir_nxt   = dir;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'd0: begin
                            done_nxt = 1'b1;
                            if (cmd_swap) begin
                                if (swap_ok) q_nxt = swap_img;
                                else         err_nxt = 1'b1;
                            end
                        end
                        2'd1: begin
                            q_nxt    = load_data;
                            done_nxt = 1'b1;
                        end
                        2'd2, 2'd3: begin
                            if (amt_mod == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                state_nxt = BUSY;
                                count_nxt = amt_mod;
                                dir_nxt   = (cmd_op == 2'd3);
                            end
                        end
                    endcase
                end
            end
            BUSY: begin
                q_nxt     = dir ? rotr_img : rotl_img;
                count_nxt = count - (AW+1)'(1);
                if (count == (AW+1)'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            q     <= RESET_VAL;
            count <= '0;
            dir   <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            count <= count_nxt;
            dir   <= dir_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_lane_rotator.sv
// Bench for lane_rotator with 4 lanes of 8 bits: vector table plus hand-written
// sequences for busy-ignore, back-to-back accepts and reset during a rotate.
module tb_lane_rotator;

    localparam int N = 4;
    localparam int W = 8;
    localparam int AW = 4;
    localparam logic [31:0] RST_IMG = 32'h0D0C_0B0A;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic          cmd_swap = 1'b0;
    logic [AW-1:0] cmd_amt = '0;
    logic [AW-1:0] swap_a = '0;
    logic [AW-1:0] swap_b = '0;
    logic [31:0]   load_data = '0;
    logic [31:0]   q;
    logic          done;
    logic          err;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] q;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic        swp;
        logic [3:0]  amt;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [31:0] data;
        logic [31:0] exp_q;
        logic        exp_err;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];

    lane_rotator #(
        .N(N), .W(W), .AW(AW), .RESET_VAL(RST_IMG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_swap(cmd_swap),
        .cmd_amt(cmd_amt),
        .swap_a(swap_a),
        .swap_b(swap_b),
        .load_data(load_data),
        .q(q),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic swp, input logic [3:0] amt,
                         input logic [3:0] a, input logic [3:0] b, input logic [31:0] data);
        cmd_op    = op;
        cmd_swap  = swp;
        cmd_amt   = amt;
        swap_a    = a;
        swap_b    = b;
        load_data = data;
        cmd_valid = 1'b1;
    endtask

    // wait (bounded) for a done pulse, then pop and compare the scoreboard head
    task automatic collect(input string name);
        int   n = 0;
        exp_t e;
        while (done !== 1'b1 && n < 40) begin
            check({name, " ready_while_busy"}, 32'(cmd_ready), 32'(0));
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            check({name, " done_timeout"}, 32'(done), 32'(1));
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: done pulse with no expected completion", name);
            return;
        end
        e = sb.pop_front();
        check({name, " q"}, q, e.q);
        check({name, " err"}, 32'(err), 32'(e.err));
        check({name, " done_cycle"}, 32'(cyc), 32'(e.due));
        check({name, " ready_at_done"}, 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        int seen;
        //            op    swp   amt    a      b      data           exp_q          err   lat
        vecs[0]  = '{2'd0, 1'b1, 4'd0,  4'd0,  4'd1,  32'h0,         32'h0D0C_0A0B, 1'b0, 1};
        vecs[1]  = '{2'd0, 1'b1, 4'd0,  4'd4,  4'd1,  32'h0,         32'h0D0C_0A0B, 1'b1, 1};
        vecs[2]  = '{2'd0, 1'b1, 4'd0,  4'd2,  4'd2,  32'h0,         32'h0D0C_0A0B, 1'b0, 1};
        vecs[3]  = '{2'd0, 1'b1, 4'd0,  4'd1,  4'd15, 32'h0,         32'h0D0C_0A0B, 1'b1, 1};
        vecs[4]  = '{2'd0, 1'b0, 4'd0,  4'd0,  4'd1,  32'hFFFF_FFFF, 32'h0D0C_0A0B, 1'b0, 1};
        vecs[5]  = '{2'd1, 1'b0, 4'd0,  4'd0,  4'd0,  32'h4433_2211, 32'h4433_2211, 1'b0, 1};
        vecs[6]  = '{2'd2, 1'b0, 4'd1,  4'd0,  4'd0,  32'h0,         32'h1144_3322, 1'b0, 2};
        vecs[7]  = '{2'd1, 1'b0, 4'd0,  4'd0,  4'd0,  32'h4433_2211, 32'h4433_2211, 1'b0, 1};
        vecs[8]  = '{2'd3, 1'b0, 4'd6,  4'd0,  4'd0,  32'h0,         32'h2211_4433, 1'b0, 3};
        vecs[9]  = '{2'd2, 1'b0, 4'd4,  4'd0,  4'd0,  32'h0,         32'h2211_4433, 1'b0, 1};
        vecs[10] = '{2'd2, 1'b0, 4'd3,  4'd0,  4'd0,  32'h0,         32'h1144_3322, 1'b0, 4};
        vecs[11] = '{2'd0, 1'b1, 4'd0,  4'd3,  4'd0,  32'h0,         32'h2244_3311, 1'b0, 1};
        vecs[12] = '{2'd3, 1'b0, 4'd15, 4'd0,  4'd0,  32'h0,         32'h1122_4433, 1'b0, 4};
        vecs[13] = '{2'd1, 1'b1, 4'd0,  4'd0,  4'd1,  32'hA1B2_C3D4, 32'hA1B2_C3D4, 1'b0, 1};

        repeat (2) tick();
        check("reset q_during", q, RST_IMG);
        reset = 1'b0;
        tick();
        check("reset q", q, RST_IMG);
        check("reset ready", 32'(cmd_ready), 32'(1));
        check("reset done", 32'(done), 32'(0));
        check("reset err", 32'(err), 32'(0));

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].swp, vecs[i].amt, vecs[i].a, vecs[i].b, vecs[i].data);
            sb.push_back('{vecs[i].exp_q, vecs[i].exp_err, cyc + vecs[i].lat});
            tick();
            cmd_valid = 1'b0;
            collect($sformatf("vec%0d", i));
            tick();
            check($sformatf("vec%0d done_pulse_end", i), 32'(done), 32'(0));
            check($sformatf("vec%0d err_pulse_end", i), 32'(err), 32'(0));
        end

        // commands presented while busy must be dropped
        drive(2'd2, 1'b0, 4'd2, 4'd0, 4'd0, 32'h0);
        sb.push_back('{32'hC3D4_A1B2, 1'b0, cyc + 3});
        tick();
        drive(2'd1, 1'b0, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF);
        tick();
        cmd_valid = 1'b0;
        collect("busy_ignore");
        tick();
        check("busy_ignore q_after", q, 32'hC3D4_A1B2);
        check("busy_ignore done_end", 32'(done), 32'(0));

        // LOAD then SWAP on consecutive edges with cmd_valid held
        drive(2'd1, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0102_0304);
        sb.push_back('{32'h0102_0304, 1'b0, cyc + 1});
        tick();
        drive(2'd0, 1'b1, 4'd0, 4'd0, 4'd3, 32'h0);
        sb.push_back('{32'h0402_0301, 1'b0, cyc + 1});
        collect("b2b_load");
        tick();
        cmd_valid = 1'b0;
        collect("b2b_swap");
        tick();
        check("b2b done_end", 32'(done), 32'(0));

        // reset lands after two of three rotate steps
        drive(2'd2, 1'b0, 4'd3, 4'd0, 4'd0, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("abort ready_busy", 32'(cmd_ready), 32'(0));
        check("abort q_mid", q, 32'h0301_0402);
        reset = 1'b1;
        #1;
        check("abort q_reset", q, RST_IMG);
        check("abort ready", 32'(cmd_ready), 32'(1));
        check("abort done", 32'(done), 32'(0));
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done !== 1'b0) seen++;
        end
        check("abort no_done", 32'(seen), 32'(0));
        check("abort q_hold", q, RST_IMG);
        check("abort sb_empty", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
